// File: rtl/serial_comp_seq.sv
// Bit-serial magnitude comparator sequencer.
// Two WIDTH-bit operands and three cascade flags are captured over a
// valid/ready handshake, compared one bit per clock through a single-bit
// compare stage, and the one-hot G/EQ/L result is returned over a second
// valid/ready handshake. The G/EQ/L running state is held in registers
// between bits, so the datapath is one bit wide regardless of WIDTH.
//
// MSB_FIRST = 0: bits are scanned LSB to MSB. The running state is seeded
//   from the decoded cascade flags and every differing bit overrides it, so
//   the most significant differing bit (scanned last) wins. Latency is
//   always WIDTH cycles.
// MSB_FIRST = 1: bits are scanned MSB to LSB. The first differing bit
//   decides the result and ends the scan on that edge; the decoded cascade
//   flags are the result only when every bit matches. Latency is 1..WIDTH.
//
// WIDTH must be 2 or greater.
module serial_comp_seq #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             great_in,
    input  logic             equal_in,
    input  logic             less_in,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             G,
    output logic             EQ,
    output logic             L,
    output logic             cascade_err,
    output logic             busy
);

    // Bit index is exactly wide enough to address every operand bit.
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(WIDTH - 1);
    localparam logic [IW-1:0] START_IDX = MSB_FIRST ? LAST_IDX : '0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    // Running comparison state between bits; neither set means "equal so far".
    logic             acc_g;
    logic             acc_l;
    logic             flag_err;

    // Decoded cascade flags at the capture point.
    logic             seed_g;
    logic             seed_l;
    logic             seed_err;
    logic [1:0]       flag_count;

    // Single-bit compare stage.
    logic             bit_a;
    logic             bit_b;
    logic             bit_gt;
    logic             bit_lt;
    logic             step_g;
    logic             step_l;
    logic             step_last;

    // Decode the cascade flags with priority great > less > equal; no flag means equal.
    always_comb begin
        flag_count = {1'b0, great_in} + {1'b0, less_in} + {1'b0, equal_in};
        seed_g     = great_in;
        seed_l     = !great_in && less_in;
        seed_err   = (flag_count != 2'd1);
    end

    // Compare the current bit and work out the next running state and whether the scan ends.
    always_comb begin
        bit_a  = a_reg[idx];
        bit_b  = b_reg[idx];
        bit_gt = bit_a && !bit_b;
        bit_lt = !bit_a && bit_b;
        if (MSB_FIRST) begin
            // First differing bit from the top decides; otherwise keep the cascade seed.
            if (bit_gt || bit_lt) begin
                step_g = bit_gt;
                step_l = bit_lt;
            end else begin
                step_g = acc_g;
                step_l = acc_l;
            end
            step_last = bit_gt || bit_lt || (idx == '0);
        end else begin
            // A differing bit overrides whatever lower bits or the cascade decided.
            step_g    = bit_gt || (acc_g && !bit_lt);
            step_l    = bit_lt || (acc_l && !bit_gt);
            step_last = (idx == LAST_IDX);
        end
    end

    // Sequencer: capture, serial scan, result hold; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            acc_g       <= 1'b0;
            acc_l       <= 1'b0;
            flag_err    <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            G           <= 1'b0;
            EQ          <= 1'b0;
            L           <= 1'b0;
            cascade_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        acc_g    <= seed_g;
                        acc_l    <= seed_l;
                        flag_err <= seed_err;
                        idx      <= START_IDX;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (abort) begin
                        // Cancel drops the operation silently; no result is produced.
                        idx      <= '0;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end else if (step_last) begin
                        G           <= step_g;
                        L           <= step_l;
                        EQ          <= !step_g && !step_l;
                        cascade_err <= flag_err;
                        out_valid   <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end else begin
                        acc_g <= step_g;
                        acc_l <= step_l;
                        idx   <= MSB_FIRST ? (idx - IW'(1)) : (idx + IW'(1));
                    end
                end

                DONE: begin
                    // Result holds until taken; in_ready returns one cycle after the handshake.
                    if (out_ready) begin
                        out_valid   <= 1'b0;
                        G           <= 1'b0;
                        EQ          <= 1'b0;
                        L           <= 1'b0;
                        cascade_err <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    out_valid   <= 1'b0;
                    G           <= 1'b0;
                    EQ          <= 1'b0;
                    L           <= 1'b0;
                    cascade_err <= 1'b0;
                    busy        <= 1'b0;
                    in_ready    <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comp_seq.sv
// Testbench for serial_comp_seq: four instances (WIDTH 4/7 x MSB_FIRST 0/1),
// directed vector table, hand-written abort/reset/backpressure sequences and
// randomized transactions checked against a magnitude-based reference model.
module tb_serial_comp_seq;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_valid_v, in_ready_v, gi_v, ei_v, li_v, abort_v;
    logic [3:0] out_valid_v, out_ready_v, g_v, eq_v, l_v, err_v, busy_v;
    logic [6:0] a_v [4];
    logic [6:0] b_v [4];

    int cfg_w [4] = '{4, 4, 7, 7};
    int cfg_m [4] = '{0, 1, 0, 1};

    int    n_cmp = 0;
    int    n_bad = 0;
    string cur   = "";

    typedef struct {
        int         k;
        logic [6:0] a;
        logic [6:0] b;
        logic       gi, ei, li;
        logic       eg, ee, el, eerr;
        int         lat;
    } vec_t;

    vec_t vecs [12];

    serial_comp_seq #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][3:0]), .b(b_v[0][3:0]), .great_in(gi_v[0]), .equal_in(ei_v[0]),
        .less_in(li_v[0]), .abort(abort_v[0]), .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]), .G(g_v[0]), .EQ(eq_v[0]), .L(l_v[0]),
        .cascade_err(err_v[0]), .busy(busy_v[0]));

    serial_comp_seq #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][3:0]), .b(b_v[1][3:0]), .great_in(gi_v[1]), .equal_in(ei_v[1]),
        .less_in(li_v[1]), .abort(abort_v[1]), .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]), .G(g_v[1]), .EQ(eq_v[1]), .L(l_v[1]),
        .cascade_err(err_v[1]), .busy(busy_v[1]));

    serial_comp_seq #(.WIDTH(7), .MSB_FIRST(1'b0)) u_w7_lsb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .great_in(gi_v[2]), .equal_in(ei_v[2]),
        .less_in(li_v[2]), .abort(abort_v[2]), .out_valid(out_valid_v[2]),
        .out_ready(out_ready_v[2]), .G(g_v[2]), .EQ(eq_v[2]), .L(l_v[2]),
        .cascade_err(err_v[2]), .busy(busy_v[2]));

    serial_comp_seq #(.WIDTH(7), .MSB_FIRST(1'b1)) u_w7_msb (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_v[3]),
        .a(a_v[3]), .b(b_v[3]), .great_in(gi_v[3]), .equal_in(ei_v[3]),
        .less_in(li_v[3]), .abort(abort_v[3]), .out_valid(out_valid_v[3]),
        .out_ready(out_ready_v[3]), .G(g_v[3]), .EQ(eq_v[3]), .L(l_v[3]),
        .cascade_err(err_v[3]), .busy(busy_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%s]: got %b, expected %b", name, cur, act, exp);
        end
    endtask

    task automatic chkn(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s [%s]: got %0d, expected %0d", name, cur, act, exp);
        end
    endtask

    // Reference: result is a plain magnitude compare; equal operands fall back
    // to the cascade flags (great > less > equal, none = equal). Latency is
    // WIDTH for LSB-first; for MSB-first it is the position of the top
    // differing bit counted from the MSB (WIDTH when the operands match).
    function automatic void ref_model(input int w, input int m,
                                      input logic [6:0] av, input logic [6:0] bv,
                                      input logic gi, input logic ei, input logic li,
                                      output logic eg, output logic ee, output logic el,
                                      output logic eerr, output int lat);
        int ones;
        ones = int'(gi) + int'(ei) + int'(li);
        eerr = (ones != 1);
        if (av > bv)      {eg, ee, el} = 3'b100;
        else if (av < bv) {eg, ee, el} = 3'b001;
        else if (gi)      {eg, ee, el} = 3'b100;
        else if (li)      {eg, ee, el} = 3'b001;
        else              {eg, ee, el} = 3'b010;
        lat = w;
        if (m == 1) begin
            for (int i = w - 1; i >= 0; i--) begin
                if (av[i] != bv[i]) begin
                    lat = w - i;
                    break;
                end
            end
        end
    endfunction

    // One full transaction on instance k. Entered and left just after a negedge.
    task automatic do_compare(input int k, input logic [6:0] av, input logic [6:0] bv,
                              input logic gi, input logic ei, input logic li,
                              input int stall,
                              input logic eg, input logic ee, input logic el,
                              input logic eerr, input int elat);
        int   cnt;
        int   busy_cnt;
        logic sv, sg, se, sl, serr;
        a_v[k] = av; b_v[k] = bv;
        gi_v[k] = gi; ei_v[k] = ei; li_v[k] = li;
        out_ready_v[k] = 1'b0;
        in_valid_v[k] = 1'b1;
        chk1("in_ready_before_accept", in_ready_v[k], 1'b1);
        @(posedge clk);
        @(negedge clk);
        // Inputs change after accept; the result must not depend on them.
        in_valid_v[k] = 1'b0;
        a_v[k] = ~av; b_v[k] = av;
        gi_v[k] = ~gi; ei_v[k] = ~ei; li_v[k] = ~li;
        cnt = 0;
        busy_cnt = 0;
        while (out_valid_v[k] !== 1'b1 && cnt < 20) begin
            if (busy_v[k] === 1'b1) busy_cnt++;
            chkn("flags_low_without_valid", int'({g_v[k], eq_v[k], l_v[k]}), 0);
            @(negedge clk);
            cnt++;
        end
        chkn("latency", cnt, elat);
        chkn("busy_cycles", busy_cnt, elat);
        chk1("G", g_v[k], eg);
        chk1("EQ", eq_v[k], ee);
        chk1("L", l_v[k], el);
        chk1("cascade_err", err_v[k], eerr);
        chkn("onehot", int'(g_v[k]) + int'(eq_v[k]) + int'(l_v[k]), 1);
        chk1("busy_in_done", busy_v[k], 1'b0);
        chk1("in_ready_in_done", in_ready_v[k], 1'b0);
        sv = out_valid_v[k]; sg = g_v[k]; se = eq_v[k]; sl = l_v[k]; serr = err_v[k];
        for (int s = 0; s < stall; s++) begin
            // A new request while the result waits must be ignored.
            in_valid_v[k] = 1'b1;
            a_v[k] = 7'($urandom);
            b_v[k] = 7'($urandom);
            @(negedge clk);
            chkn("hold_result", int'({out_valid_v[k], g_v[k], eq_v[k], l_v[k], err_v[k]}),
                 int'({sv, sg, se, sl, serr}));
            chk1("in_ready_stalled", in_ready_v[k], 1'b0);
        end
        in_valid_v[k] = 1'b0;
        out_ready_v[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready_v[k] = 1'b0;
        chkn("cleared_after_handshake", int'({out_valid_v[k], g_v[k], eq_v[k], l_v[k], err_v[k]}), 0);
        chk1("in_ready_after_handshake", in_ready_v[k], 1'b1);
    endtask

    initial begin
        int   k, w, stall, lat;
        logic [6:0] av, bv, mask;
        logic [2:0] fl;
        logic eg, ee, el, eerr;
        logic seen_valid;

        vecs[0]  = '{0, 7'b0001010, 7'b0000110, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        vecs[1]  = '{0, 7'b0000101, 7'b0000101, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[2]  = '{0, 7'b0000101, 7'b0000101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4};
        vecs[3]  = '{0, 7'b0000101, 7'b0000101, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        vecs[4]  = '{1, 7'b0001000, 7'b0000111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        vecs[5]  = '{1, 7'b0000011, 7'b0000010, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4};
        vecs[6]  = '{1, 7'b0001111, 7'b0001111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4};
        vecs[7]  = '{2, 7'h40,      7'h3F,      1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7};
        vecs[8]  = '{3, 7'h01,      7'h40,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[9]  = '{0, 7'b0000001, 7'b0001000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        vecs[10] = '{1, 7'b0000000, 7'b0000000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4};
        vecs[11] = '{1, 7'b0000100, 7'b0000110, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3};

        in_valid_v = '0; gi_v = '0; ei_v = '0; li_v = '0; abort_v = '0; out_ready_v = '0;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = '0;
            b_v[i] = '0;
        end

        // Asynchronous reset before any clock edge.
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            cur = $sformatf("reset k%0d", i);
            chk1("reset_in_ready", in_ready_v[i], 1'b1);
            chkn("reset_outputs", int'({out_valid_v[i], g_v[i], eq_v[i], l_v[i], err_v[i], busy_v[i]}), 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            cur = $sformatf("vec%0d", i);
            do_compare(vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].gi, vecs[i].ei, vecs[i].li, 0,
                       vecs[i].eg, vecs[i].ee, vecs[i].el, vecs[i].eerr, vecs[i].lat);
        end

        // Backpressure: result held for 5 stalled cycles with a pending request.
        cur = "backpressure";
        do_compare(0, 7'b0000011, 7'b0001100, 1'b0, 1'b1, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b0, 4);

        // Abort during the second RUN cycle.
        cur = "abort";
        a_v[0] = 7'b0000000; b_v[0] = 7'b0001111;
        gi_v[0] = 1'b0; ei_v[0] = 1'b1; li_v[0] = 1'b0;
        in_valid_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[0] = 1'b0;
        @(negedge clk);
        chk1("busy_before_abort", busy_v[0], 1'b1);
        abort_v[0] = 1'b1;
        @(negedge clk);
        abort_v[0] = 1'b0;
        chk1("in_ready_after_abort", in_ready_v[0], 1'b1);
        chk1("busy_after_abort", busy_v[0], 1'b0);
        seen_valid = out_valid_v[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen_valid = seen_valid | out_valid_v[0] | g_v[0] | eq_v[0] | l_v[0];
        end
        chk1("no_result_after_abort", seen_valid, 1'b0);
        cur = "after_abort";
        do_compare(0, 7'b0000110, 7'b0000110, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 4);

        // Asynchronous reset in the middle of RUN.
        cur = "reset_mid_run";
        a_v[2] = 7'h55; b_v[2] = 7'h2A;
        gi_v[2] = 1'b0; ei_v[2] = 1'b1; li_v[2] = 1'b0;
        in_valid_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid_v[2] = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk1("reset_in_ready", in_ready_v[2], 1'b1);
        chkn("reset_outputs", int'({out_valid_v[2], g_v[2], eq_v[2], l_v[2], err_v[2], busy_v[2]}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cur = "after_reset";
        do_compare(2, 7'h2A, 7'h55, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 7);

        // Randomized transactions against the reference model.
        for (int n = 0; n < 1000; n++) begin
            k    = $urandom_range(0, 3);
            w    = cfg_w[k];
            mask = 7'((1 << w) - 1);
            av   = 7'($urandom) & mask;
            bv   = ($urandom_range(0, 3) == 0) ? av : (7'($urandom) & mask);
            fl   = 3'($urandom);
            stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            ref_model(w, cfg_m[k], av, bv, fl[2], fl[1], fl[0], eg, ee, el, eerr, lat);
            cur = $sformatf("rnd%0d k%0d a=%0h b=%0h f=%b", n, k, av, bv, fl);
            do_compare(k, av, bv, fl[2], fl[1], fl[0], stall, eg, ee, el, eerr, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_comp_seq.md
Name: serial_comp_seq

Overview:
- Bit-serial magnitude-comparator sequencer: accepts two WIDTH-bit operands plus cascade flags over a valid/ready handshake.
- Evaluates one bit per clock using single-bit compare-stage logic, with the G/EQ/L state registered between bits.
- Returns a one-hot G/EQ/L result over a second valid/ready handshake.
- Replaces the unrolled ripple comparator where area matters; its flags cascade into wider compare chains.

Parameters:
- WIDTH, 4, operand width in bits; legal range is 2 or greater.
- MSB_FIRST, 0. 0 = scan LSB to MSB; higher bits override lower bits and the cascade input seeds the state. 1 = scan MSB to LSB with early exit on the first differing bit; the cascade input decides only if all bits are equal.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_valid, in, 1, operand request.
- in_ready, out, 1, high only in IDLE.
- a, in, WIDTH, operand A; captured on accept.
- b, in, WIDTH, operand B; captured on accept.
- great_in, in, 1, cascade flag from the less-significant stage.
- equal_in, in, 1, cascade flag.
- less_in, in, 1, cascade flag.
- abort, in, 1, synchronous cancel.
- out_valid, out, 1, result valid.
- out_ready, in, 1, result consumer ready.
- G, out, 1, A greater than B.
- EQ, out, 1, A equal to B.
- L, out, 1, A less than B.
- cascade_err, out, 1, captured cascade flags were not one-hot.
- busy, out, 1, high in RUN.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid, G, EQ, L, cascade_err and busy all 0; bit index cleared; operand registers cleared. Reset during RUN or DONE discards the operation with no result.
- States: IDLE, RUN, DONE. Bit index is a ceil(log2(WIDTH))-bit counter.
- IDLE:
  - in_ready=1.
  - Accept when in_valid=1 at a clk edge: capture a, b and the cascade flags, set index (0 if MSB_FIRST=0, else WIDTH-1), go to RUN.
- Cascade decode at capture, priority great > less > equal:
  - No flag set decodes to equal.
  - cascade_err is set when the popcount of the three flags is not 1; it is held with the result.
- RUN (busy=1, in_ready=0), one bit per cycle:
  - MSB_FIRST=0: a[i]>b[i] gives state G; a[i]<b[i] gives state L; equal bits keep the state. After i=WIDTH-1, go to DONE. A result is presented exactly WIDTH cycles after the accept edge.
  - MSB_FIRST=1: the first i with a[i]!=b[i] sets G or L and goes to DONE on that edge. If all bits are equal, the decoded cascade flag is the result, WIDTH cycles after accept. Latency is 1..WIDTH cycles.
  - abort=1 in RUN: go to IDLE next edge; no out_valid; G/EQ/L stay 0. abort is ignored in IDLE and DONE.
- DONE:
  - out_valid=1; exactly one of G/EQ/L is 1; outputs hold stable until out_ready=1.
  - On the out_ready edge: go to IDLE, clear G/EQ/L/out_valid/cascade_err.
  - in_ready rises the cycle after the result handshake; no same-cycle turnaround.
- G/EQ/L are 0 whenever out_valid=0.
- Operand or cascade input changes after accept have no effect.
- Throughput: one compare per WIDTH+2 cycles maximum (MSB_FIRST=0, out_ready held high).

Test Plan:
- WIDTH=4, MSB_FIRST=0: a=4'b1010, b=4'b0110, equal_in=1, accept at edge 0 -> out_valid at edge 4 with G=1, EQ=0, L=0, cascade_err=0; busy high for exactly 4 cycles.
- WIDTH=4, MSB_FIRST=0: a=b=4'b0101 with less_in=1 -> L=1. Repeat with equal_in=1 -> EQ=1. Repeat with great_in=1 and less_in=1 -> G=1 and cascade_err=1.
- WIDTH=4, MSB_FIRST=1: a=4'b1000, b=4'b0111 -> G=1 at edge 1. a=4'b0011, b=4'b0010 -> G=1 at edge 4. a=b=4'b1111 with no cascade flag -> EQ=1, cascade_err=1.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and G/EQ/L held constant, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge, in_ready=1 the following cycle.
- Abort/reset: abort at 2nd RUN cycle -> IDLE next edge, no out_valid pulse. rst_n low asynchronously mid-RUN -> all outputs 0 immediately, in_ready=1; a fresh compare after release produces the correct result.
- Random: 1000 random a/b/flag triples with random out_ready stalls, both MSB_FIRST values, WIDTH=4 and WIDTH=7 -> every result matches the reference model, G/EQ/L always one-hot, result latency within the stated bounds.
